card_deal_scheduler: RTL and testbench

Control-path scheduler that shares the four seed_random card generators among the card requesters (player, dealer).
- Arbitrates requests round-robin.
- Issues a one-cycle request to the next generator in rotation, waits for its card, sanitises the value and returns it with an ack.
- Sits between the game FSM's request lines and the seed_random_N blocks.
- Also reports busy, timeout and deal count.

---
 rtl/card_deal_scheduler.sv | 249 ++++++++++++++++++++++++
 tb/tb_card_deal_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_deal_scheduler.sv
// card_deal_scheduler
// Shares N_GEN card generators among N_REQ requesters. Requests are granted
// round-robin. Each deal issues a one-cycle request to the next generator in
// rotation and waits for that generator's card. The raw value is cleaned up
// before it is returned with an ack. A deal is aborted with err_o after
// too many invalid cards or after a silent generator times out.
module card_deal_scheduler #(
    parameter int N_REQ     = 2,
    parameter int N_GEN     = 4,
    parameter int TIMEOUT   = 15,
    parameter int MAX_RETRY = 3
) (
    input  logic               clk_cp_i,
    input  logic               rst_cp_i,
    input  logic [N_REQ-1:0]   req_i,
    output logic [N_REQ-1:0]   ack_o,
    output logic               err_o,
    output logic [3:0]         card_o,
    output logic [N_GEN-1:0]   gen_req_o,
    input  logic [N_GEN-1:0]   gen_valid_i,
    input  logic [4*N_GEN-1:0] gen_card_i,
    output logic               busy_o,
    output logic [5:0]         deal_cnt_o
);

    localparam int REQ_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GEN_W   = (N_GEN > 1) ? $clog2(N_GEN) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [7:0]         TIMEOUT_C   = 8'(TIMEOUT);
    localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);
    localparam logic [5:0]         CNT_MAX     = 6'd63;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DELIVER
    } state_e;

    state_e state_q, state_d;

    logic [REQ_W-1:0]   owner_q, owner_d;
    logic [REQ_W-1:0]   rr_q, rr_d;
    logic [GEN_W-1:0]   gen_ptr_q, gen_ptr_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [7:0]         timer_q, timer_d;
    logic [3:0]         card_q, card_d;
    logic               err_q, err_d;
    logic [5:0]         cnt_q, cnt_d;

    // Round-robin search scratch.
    logic [REQ_W:0]     rr_sum;
    logic [REQ_W-1:0]   winner;
    logic               found;

    // Selected generator response and its cleaned-up value.
    logic               sel_valid;
    logic [3:0]         raw_card;
    logic               raw_ok;
    logic [3:0]         clean_card;
    logic [7:0]         timer_inc;
    logic               timeout_hit;
    logic               retry_exhausted;
    logic [GEN_W-1:0]   gen_ptr_next;
    logic [REQ_W-1:0]   owner_next;

    // Only the generator currently pointed at is listened to.
    assign sel_valid       = gen_valid_i[gen_ptr_q];
    assign raw_card        = gen_card_i[{gen_ptr_q, 2'b00} +: 4];
    assign raw_ok          = (raw_card != 4'd0);
    // 14 and 15 fold back onto 1 and 2; 0 is the only unusable value.
    assign clean_card      = (raw_card > 4'd13) ? (raw_card - 4'd13) : raw_card;
    assign timer_inc       = timer_q + 8'd1;
    assign timeout_hit     = (timer_inc >= TIMEOUT_C);
    assign retry_exhausted = (retry_q == MAX_RETRY_C);
    assign gen_ptr_next    = (gen_ptr_q == GEN_W'(N_GEN - 1)) ? '0 : gen_ptr_q + GEN_W'(1);
    assign owner_next      = (owner_q == REQ_W'(N_REQ - 1)) ? '0 : owner_q + REQ_W'(1);

    // Round-robin winner: first set request at or after rr_q, wrapping.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        winner = rr_q;
        found  = 1'b0;
        rr_sum = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rr_sum = {1'b0, rr_q} + (REQ_W + 1)'(i);
            if (rr_sum >= (REQ_W + 1)'(N_REQ)) begin
                rr_sum = rr_sum - (REQ_W + 1)'(N_REQ);
            end
            if (!found && req_i[rr_sum[REQ_W-1:0]]) begin
                found  = 1'b1;
                winner = rr_sum[REQ_W-1:0];
            end
        end
    end

    // FSM state register; reset forces IDLE from any state, including WAIT.
    always_ff @(posedge clk_cp_i) begin
        // NOTE: sequential state uses non-blocking (<=) assignments so every
        // register samples its next value at the same edge.
        if (rst_cp_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sel_valid) begin
                    if (raw_ok || retry_exhausted) begin
                        state_d = S_DELIVER;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (timeout_hit) begin
                    state_d = S_DELIVER;
                end
            end
            S_DELIVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: owner, pointers, retry/timer, card and counters.
    always_comb begin
        owner_d   = owner_q;
        rr_d      = rr_q;
        gen_ptr_d = gen_ptr_q;
        retry_d   = retry_q;
        timer_d   = timer_q;
        card_d    = card_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    owner_d = winner;
                    card_d  = 4'd0;
                    err_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                timer_d = 8'd0;
            end
            S_WAIT: begin
                timer_d = timer_inc;
                if (sel_valid) begin
                    // Every outcome of an issue moves on to the next generator.
                    gen_ptr_d = gen_ptr_next;
                    if (raw_ok) begin
                        card_d = clean_card;
                    end else if (retry_exhausted) begin
                        err_d = 1'b1;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end else if (timeout_hit) begin
                    gen_ptr_d = gen_ptr_next;
                    err_d     = 1'b1;
                end
            end
            S_DELIVER: begin
                rr_d    = owner_next;
                retry_d = '0;
                if (!err_q && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_cp_i) begin
        // NOTE: the card/err holding registers are reset too, so every output
        // is defined immediately after reset rather than only after a deal.
        if (rst_cp_i) begin
            owner_q   <= '0;
            rr_q      <= '0;
            gen_ptr_q <= '0;
            retry_q   <= '0;
            timer_q   <= 8'd0;
            card_q    <= 4'd0;
            err_q     <= 1'b0;
            cnt_q     <= 6'd0;
        end else begin
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            gen_ptr_q <= gen_ptr_d;
            retry_q   <= retry_d;
            timer_q   <= timer_d;
            card_q    <= card_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        ack_o     = '0;
        err_o     = 1'b0;
        card_o    = 4'd0;
        gen_req_o = '0;
        busy_o    = (state_q != S_IDLE);
        unique case (state_q)
            S_ISSUE: begin
                gen_req_o[gen_ptr_q] = 1'b1;
            end
            S_DELIVER: begin
                ack_o[owner_q] = 1'b1;
                err_o          = err_q;
                card_o         = err_q ? 4'd0 : card_q;
            end
            default: begin
            end
        endcase
    end

    assign deal_cnt_o = cnt_q;

    // Handshake sanity: at most one ack and one generator request at a time,
    // and an aborted deal never carries a card value.
    a_ack_onehot : assert property (@(posedge clk_cp_i) disable iff (rst_cp_i)
        $onehot0(ack_o));
    a_gen_req_onehot : assert property (@(posedge clk_cp_i) disable iff (rst_cp_i)
        $onehot0(gen_req_o));
    a_err_no_card : assert property (@(posedge clk_cp_i) disable iff (rst_cp_i)
        err_o |-> (card_o == 4'd0));

endmodule

// File: tb/tb_card_deal_scheduler.sv
// Bench for card_deal_scheduler: a table of single-issue deals plus
// hand-written sequences for retries, arbitration, reset and saturation.
module tb_card_deal_scheduler;

    localparam int N_REQ = 2;
    localparam int N_GEN = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    ack;
    logic                err;
    logic [3:0]          card;
    logic [N_GEN-1:0]    gen_req;
    logic [N_GEN-1:0]    gen_valid;
    logic [4*N_GEN-1:0]  gen_card;
    logic                busy;
    logic [5:0]          cnt;

    card_deal_scheduler #(
        .N_REQ     (N_REQ),
        .N_GEN     (N_GEN),
        .TIMEOUT   (15),
        .MAX_RETRY (3)
    ) dut (
        .clk_cp_i    (clk),
        .rst_cp_i    (rst),
        .req_i       (req),
        .ack_o       (ack),
        .err_o       (err),
        .card_o      (card),
        .gen_req_o   (gen_req),
        .gen_valid_i (gen_valid),
        .gen_card_i  (gen_card),
        .busy_o      (busy),
        .deal_cnt_o  (cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- generator model ----------------
    typedef struct {
        int         delay;      // cycles after the request before valid
        logic [3:0] card;
        bit         silent;     // never answers
        bit         wrong_gen;  // answers on the neighbouring generator
    } resp_t;

    resp_t      resp_q[$];
    logic [3:0] issue_log[$];
    int         pend_cnt = 0;
    int         pend_k   = 0;
    logic [3:0] pend_card;
    int         exp_gp   = 0;

    initial begin
        int    k;
        resp_t r;
        gen_valid = '0;
        gen_card  = '0;
        forever begin
            @(negedge clk);
            gen_valid = '0;
            gen_card  = '0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    gen_valid = N_GEN'(1) << pend_k;
                    gen_card  = (4*N_GEN)'(pend_card) << (4 * pend_k);
                end
            end
            if (gen_req != '0) begin
                k = 0;
                for (int j = 0; j < N_GEN; j++) if (gen_req[j]) k = j;
                issue_log.push_back(gen_req);
                if (resp_q.size() > 0) begin
                    r = resp_q.pop_front();
                    if (!r.silent) begin
                        pend_cnt  = r.delay;
                        pend_card = r.card;
                        pend_k    = r.wrong_gen ? (k + 1) % N_GEN : k;
                    end
                end
            end
        end
    end

    task automatic push(input int d, input logic [3:0] c, input bit s, input bit w);
        resp_t r;
        r.delay = d; r.card = c; r.silent = s; r.wrong_gen = w;
        resp_q.push_back(r);
    endtask

    // Waits (bounded) for an ack and checks it; drops the acked request.
    task automatic wait_ack(input string name, input logic [1:0] exp_ack,
                            input logic [3:0] exp_card, input logic exp_err,
                            output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 300) begin
            @(negedge clk);
            lat++;
            if (ack != '0) got = 1'b1;
        end
        check($sformatf("%s ack_seen", name), 32'(got), 32'd1);
        check($sformatf("%s ack", name), 32'(ack), 32'(exp_ack));
        check($sformatf("%s card", name), 32'(card), 32'(exp_card));
        check($sformatf("%s err", name), 32'(err), 32'(exp_err));
        check($sformatf("%s busy", name), 32'(busy), 32'd1);
        req = req & ~ack;
    endtask

    // Compares the logged generator requests against the rotation.
    task automatic check_issues(input string name, input int n);
        check($sformatf("%s issues", name), 32'(issue_log.size()), 32'(n));
        for (int i = 0; i < issue_log.size(); i++) begin
            check($sformatf("%s gen_req%0d", name, i), 32'(issue_log[i]), 32'(1) << exp_gp);
            exp_gp = (exp_gp + 1) % N_GEN;
        end
        issue_log.delete();
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [1:0] req;
        int         delay;
        logic [3:0] raw;
        bit         silent;
        bit         wrong_gen;
        logic [1:0] exp_ack;
        logic [3:0] exp_card;
        logic       exp_err;
        logic [5:0] exp_cnt;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int         lat;
        int         exp_cnt;
        logic [3:0] c;

        vecs[0] = '{2'b01,  1, 4'd7,  1'b0, 1'b0, 2'b01, 4'd7,  1'b0, 6'd1};
        vecs[1] = '{2'b10,  1, 4'd14, 1'b0, 1'b0, 2'b10, 4'd1,  1'b0, 6'd2};
        vecs[2] = '{2'b01,  1, 4'd15, 1'b0, 1'b0, 2'b01, 4'd2,  1'b0, 6'd3};
        vecs[3] = '{2'b10,  1, 4'd13, 1'b0, 1'b0, 2'b10, 4'd13, 1'b0, 6'd4};
        vecs[4] = '{2'b01,  5, 4'd1,  1'b0, 1'b0, 2'b01, 4'd1,  1'b0, 6'd5};
        vecs[5] = '{2'b10,  1, 4'd9,  1'b1, 1'b0, 2'b10, 4'd0,  1'b1, 6'd5};
        vecs[6] = '{2'b01,  1, 4'd7,  1'b0, 1'b1, 2'b01, 4'd0,  1'b1, 6'd5};
        vecs[7] = '{2'b10,  1, 4'd12, 1'b0, 1'b0, 2'b10, 4'd12, 1'b0, 6'd6};
        vecs[8] = '{2'b01, 14, 4'd3,  1'b0, 1'b0, 2'b01, 4'd3,  1'b0, 6'd7};

        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        check("reset ack", 32'(ack), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset card", 32'(card), 32'd0);
        check("reset gen_req", 32'(gen_req), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset cnt", 32'(cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-issue deals.
        for (int i = 0; i < 9; i++) begin
            push(vecs[i].delay, vecs[i].raw, vecs[i].silent, vecs[i].wrong_gen);
            req = vecs[i].req;
            wait_ack($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_card,
                     vecs[i].exp_err, lat);
            if (!vecs[i].exp_err)
                check($sformatf("vec%0d latency", i), 32'(lat), 32'(2 + vecs[i].delay));
            else
                check($sformatf("vec%0d timeout_lat", i), 32'(lat >= 17 && lat <= 18), 32'd1);
            @(negedge clk);
            check($sformatf("vec%0d cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
            check_issues($sformatf("vec%0d", i), 1);
        end

        // Invalid card then reissue to the next generator.
        push(1, 4'd0, 1'b0, 1'b0);
        push(1, 4'd12, 1'b0, 1'b0);
        req = 2'b10;
        wait_ack("retry_ok", 2'b10, 4'd12, 1'b0, lat);
        @(negedge clk);
        check("retry_ok cnt", 32'(cnt), 32'd8);
        check_issues("retry_ok", 2);

        // Four invalid cards: abort after the fourth issue.
        repeat (4) push(1, 4'd0, 1'b0, 1'b0);
        req = 2'b01;
        wait_ack("retry_abort", 2'b01, 4'd0, 1'b1, lat);
        @(negedge clk);
        check("retry_abort cnt", 32'(cnt), 32'd8);
        check_issues("retry_abort", 4);

        // Three invalid cards are still within budget (retry cleared by abort).
        repeat (3) push(1, 4'd0, 1'b0, 1'b0);
        push(1, 4'd6, 1'b0, 1'b0);
        req = 2'b10;
        wait_ack("retry_max", 2'b10, 4'd6, 1'b0, lat);
        @(negedge clk);
        check("retry_max cnt", 32'(cnt), 32'd9);
        check_issues("retry_max", 4);

        // Reset in WAIT; the late generator answer must be ignored.
        push(3, 4'd9, 1'b0, 1'b0);
        req = 2'b01;
        @(negedge clk);
        check("rst_wait issue", 32'(gen_req), 32'(1) << exp_gp);
        @(negedge clk);
        check("rst_wait busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("rst_wait ack", 32'(ack), 32'd0);
        check("rst_wait err", 32'(err), 32'd0);
        check("rst_wait card", 32'(card), 32'd0);
        check("rst_wait gen_req", 32'(gen_req), 32'd0);
        check("rst_wait busy", 32'(busy), 32'd0);
        check("rst_wait cnt", 32'(cnt), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("late_valid busy%0d", i), 32'(busy), 32'd0);
            check($sformatf("late_valid gen_req%0d", i), 32'(gen_req), 32'd0);
            check($sformatf("late_valid ack%0d", i), 32'(ack), 32'd0);
        end
        @(negedge clk);
        check("late_valid cnt", 32'(cnt), 32'd0);
        issue_log.delete();
        exp_gp = 0;

        // Simultaneous requests from reset: player then dealer.
        push(1, 4'd4, 1'b0, 1'b0);
        push(1, 4'd11, 1'b0, 1'b0);
        req = 2'b11;
        wait_ack("pair1_first", 2'b01, 4'd4, 1'b0, lat);
        wait_ack("pair1_second", 2'b10, 4'd11, 1'b0, lat);
        @(negedge clk);
        check("pair1 cnt", 32'(cnt), 32'd2);
        check_issues("pair1", 2);

        // A player-only deal moves the round-robin pointer to the dealer.
        push(1, 4'd8, 1'b0, 1'b0);
        req = 2'b01;
        wait_ack("solo", 2'b01, 4'd8, 1'b0, lat);
        @(negedge clk);
        check("solo cnt", 32'(cnt), 32'd3);
        check_issues("solo", 1);

        // Second simultaneous pair: dealer first.
        push(1, 4'd10, 1'b0, 1'b0);
        push(1, 4'd5, 1'b0, 1'b0);
        req = 2'b11;
        wait_ack("pair2_first", 2'b10, 4'd10, 1'b0, lat);
        wait_ack("pair2_second", 2'b01, 4'd5, 1'b0, lat);
        @(negedge clk);
        check("pair2 cnt", 32'(cnt), 32'd5);
        check_issues("pair2", 2);

        // 64 more successful deals: the counter saturates at 63.
        exp_cnt = 5;
        for (int i = 0; i < 64; i++) begin
            c = 4'((i % 13) + 1);
            push(1, c, 1'b0, 1'b0);
            req = 2'b01;
            wait_ack($sformatf("sat%0d", i), 2'b01, c, 1'b0, lat);
            @(negedge clk);
            exp_cnt = (exp_cnt < 63) ? exp_cnt + 1 : 63;
            check($sformatf("sat%0d cnt", i), 32'(cnt), 32'(exp_cnt));
            issue_log.delete();
        end
        check("sat_final cnt", 32'(cnt), 32'd63);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
